acs_matrix_ctrl: RTL and testbench

ACS_MATRIX_CTRL -- requirements
Module: acs_matrix_ctrl

---
 rtl/acs_matrix_ctrl.sv | 142 ++++++++++++++
 tb/tb_acs_matrix_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acs_matrix_ctrl.sv
// Block controller for a Viterbi ACS matrix: gathers one block of code symbols,
// waits out the matrix pipeline, picks the minimum-metric survivor and hands it off.
module acs_matrix_ctrl #(
  parameter int LATENCY = 8,
  parameter int PM_W    = 7,
  parameter int DW      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      sym_in,
  input  logic            sym_valid,
  output logic            sym_ready,
  input  logic            flush,
  output logic [1:0]      data_recv_1,
  output logic [1:0]      data_recv_2,
  output logic [1:0]      data_recv_3,
  output logic [1:0]      data_recv_4,
  output logic [1:0]      data_recv_5,
  output logic [1:0]      data_recv_6,
  output logic [1:0]      data_recv_7,
  output logic [1:0]      data_recv_8,
  input  logic [PM_W-1:0] PM_in_1,
  input  logic [PM_W-1:0] PM_in_2,
  input  logic [PM_W-1:0] PM_in_3,
  input  logic [PM_W-1:0] PM_in_4,
  input  logic [DW-1:0]   data_in_1,
  input  logic [DW-1:0]   data_in_2,
  input  logic [DW-1:0]   data_in_3,
  input  logic [DW-1:0]   data_in_4,
  output logic [DW-1:0]   dec_out,
  output logic [1:0]      dec_state,
  output logic [PM_W-1:0] dec_metric,
  output logic            dec_sat,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic            busy,
  output logic [7:0]      blk_cnt
);

  localparam int HC_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {FILL, HOLD, PICK, OUT} state_t;

  state_t          state;
  logic [2:0]      fill_cnt;
  logic [HC_W-1:0] hold_cnt;
  logic [1:0]      recv [8];

  logic [1:0]      win_idx;
  logic [PM_W-1:0] win_pm;
  logic [DW-1:0]   win_data;

  function automatic logic metric_saturated(input logic [PM_W-1:0] pm);
    return pm == {PM_W{1'b1}};
  endfunction

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    win_idx  = 2'd0;
    win_pm   = PM_in_1;
    win_data = data_in_1;
    if (PM_in_2 < win_pm) begin
      win_idx = 2'd1; win_pm = PM_in_2; win_data = data_in_2;
    end
    if (PM_in_3 < win_pm) begin
      win_idx = 2'd2; win_pm = PM_in_3; win_data = data_in_3;
    end
    if (PM_in_4 < win_pm) begin
      win_idx = 2'd3; win_pm = PM_in_4; win_data = data_in_4;
    end
  end

  assign sym_ready = (state == FILL);
  assign busy      = (state != FILL);

  assign data_recv_1 = recv[0];
  assign data_recv_2 = recv[1];
  assign data_recv_3 = recv[2];
  assign data_recv_4 = recv[3];
  assign data_recv_5 = recv[4];
  assign data_recv_6 = recv[5];
  assign data_recv_7 = recv[6];
  assign data_recv_8 = recv[7];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FILL;
      fill_cnt   <= 3'd0;
      hold_cnt   <= '0;
      recv       <= '{default: 2'b00};
      dec_out    <= '0;
      dec_state  <= 2'd0;
      dec_metric <= '0;
      dec_sat    <= 1'b0;
      dec_valid  <= 1'b0;
      blk_cnt    <= 8'd0;
    end else if (flush) begin
      state     <= FILL;
      fill_cnt  <= 3'd0;
      hold_cnt  <= '0;
      recv      <= '{default: 2'b00};
      dec_valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (sym_valid) begin
            recv[fill_cnt] <= sym_in;
            if (fill_cnt == 3'd7) begin
              fill_cnt <= 3'd0;
              hold_cnt <= '0;
              state    <= HOLD;
            end else begin
              fill_cnt <= fill_cnt + 3'd1;
            end
          end
        end
        // Matrix columns need LATENCY+1 cycles of stable symbols before metrics settle.
        HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HC_W'(LATENCY)) state <= PICK;
        end
        PICK: begin
          dec_out    <= win_data;
          dec_state  <= win_idx;
          dec_metric <= win_pm;
          dec_sat    <= metric_saturated(win_pm);
          dec_valid  <= 1'b1;
          state      <= OUT;
        end
        OUT: begin
          if (dec_ready) begin
            dec_valid <= 1'b0;
            blk_cnt   <= blk_cnt + 8'd1;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_acs_matrix_ctrl.sv
// Randomized bench for acs_matrix_ctrl: a block-level reference model is compared
// against the DUT every cycle, plus directed checks with hand-computed values.
module tb_acs_matrix_ctrl;

  localparam int LAT = 8;
  localparam int PMW = 7;
  localparam int DWD = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      sym_in = 2'b00;
  logic            sym_valid = 1'b0;
  logic            sym_ready;
  logic            flush = 1'b0;
  logic [1:0]      rv [8];
  logic [PMW-1:0]  pm [4];
  logic [DWD-1:0]  dat [4];
  logic [DWD-1:0]  dec_out;
  logic [1:0]      dec_state;
  logic [PMW-1:0]  dec_metric;
  logic            dec_sat;
  logic            dec_valid;
  logic            dec_ready = 1'b0;
  logic            busy;
  logic [7:0]      blk_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int delivered = 0;
  bit rand_pm = 1'b0;

  acs_matrix_ctrl #(.LATENCY(LAT), .PM_W(PMW), .DW(DWD)) dut (
    .clk(clk), .rst(rst),
    .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(sym_ready), .flush(flush),
    .data_recv_1(rv[0]), .data_recv_2(rv[1]), .data_recv_3(rv[2]), .data_recv_4(rv[3]),
    .data_recv_5(rv[4]), .data_recv_6(rv[5]), .data_recv_7(rv[6]), .data_recv_8(rv[7]),
    .PM_in_1(pm[0]), .PM_in_2(pm[1]), .PM_in_3(pm[2]), .PM_in_4(pm[3]),
    .data_in_1(dat[0]), .data_in_2(dat[1]), .data_in_3(dat[2]), .data_in_4(dat[3]),
    .dec_out(dec_out), .dec_state(dec_state), .dec_metric(dec_metric), .dec_sat(dec_sat),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .busy(busy), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a block is a list of up to 8 symbols; once full, the result
  // appears LATENCY+2 edges later and is held until acknowledged.
  logic [1:0]     m_sym [8];
  int             m_n;
  int             m_wait;
  bit             m_valid;
  logic [DWD-1:0] m_out;
  logic [1:0]     m_state;
  logic [PMW-1:0] m_metric;
  logic [7:0]     m_blk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) m_sym[i] = 2'b00;
      m_n = 0; m_wait = 0; m_valid = 0; m_blk = 8'd0;
      m_out = '0; m_state = 2'd0; m_metric = '0;
    end else if (flush) begin
      for (int i = 0; i < 8; i++) m_sym[i] = 2'b00;
      m_n = 0; m_wait = 0; m_valid = 0;
    end else if (m_n < 8) begin
      if (sym_valid) begin
        m_sym[m_n] = sym_in;
        m_n++;
        m_wait = 0;
      end
    end else if (!m_valid) begin
      if (m_wait == LAT + 1) begin
        int best;
        best = 0;
        for (int i = 1; i < 4; i++) if (pm[i] < pm[best]) best = i;
        m_out = dat[best]; m_state = best[1:0]; m_metric = pm[best];
        m_valid = 1;
      end else begin
        m_wait++;
      end
    end else if (dec_ready) begin
      m_valid = 0;
      m_n = 0;
      m_blk = m_blk + 8'd1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("sym_ready", sym_ready, m_n < 8);
      chk("busy", busy, m_n >= 8);
      chk("dec_valid", dec_valid, m_valid);
      chk("blk_cnt", blk_cnt, m_blk);
      for (int i = 0; i < 8; i++) chk("data_recv", rv[i], m_sym[i]);
      if (m_valid) begin
        chk("dec_out", dec_out, m_out);
        chk("dec_state", dec_state, m_state);
        chk("dec_metric", dec_metric, m_metric);
        chk("dec_sat", dec_sat, m_metric == {PMW{1'b1}});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_pm) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom % 4)
          0: pm[i] = PMW'($urandom_range(0, 3));
          1: pm[i] = {PMW{1'b1}};
          default: pm[i] = PMW'($urandom);
        endcase
        dat[i] = DWD'($urandom);
      end
    end
  endtask

  task automatic push(input logic [1:0] s);
    int n;
    n = 0;
    sym_valid = 1'b1;
    sym_in = s;
    while (!sym_ready && n < 200) begin step(); n++; end
    if (n >= 200) chk("push_timeout", 1, 0);
    step();
    sym_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!dec_valid && cyc < 200) begin
      sym_valid = 1'($urandom); sym_in = 2'($urandom);
      step(); cyc++;
    end
    sym_valid = 1'b0;
    if (cyc >= 200) chk("valid_timeout", 1, 0);
  endtask

  task automatic ack();
    dec_ready = 1'b1; step(); dec_ready = 1'b0;
    delivered++;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [1:0] seq [8];
    int cyc;
    bit aborted;
    seq = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11, 2'b01};
    pm  = '{7'd12, 7'd5, 7'd5, 7'd30};
    dat = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    #3;
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    chk("rst_sym_ready", sym_ready, 1);
    step(); step();
    rst = 1'b1;
    chk("rel_busy", busy, 0);

    // Directed block: fixed symbols and metrics with a tie between states 1 and 2.
    for (int i = 0; i < 8; i++) push(seq[i]);
    chk("blk0_sym_ready", sym_ready, 0);
    chk("blk0_recv1", rv[0], 2'b00);
    chk("blk0_recv2", rv[1], 2'b11);
    chk("blk0_recv4", rv[3], 2'b10);
    chk("blk0_recv8", rv[7], 2'b01);
    wait_valid(cyc);
    chk("pick_latency", cyc, 10);
    chk("blk0_state", dec_state, 1);
    chk("blk0_metric", dec_metric, 5);
    chk("blk0_out", dec_out, 8'hB2);
    chk("blk0_sat", dec_sat, 0);
    for (int i = 0; i < 20; i++) begin
      sym_valid = 1'($urandom);
      step();
      chk("stall_valid", dec_valid, 1);
      chk("stall_out", dec_out, 8'hB2);
      chk("stall_ready", sym_ready, 0);
    end
    sym_valid = 1'b0;
    ack();
    chk("blk0_cnt", blk_cnt, 1);
    chk("blk0_back_fill", sym_ready, 1);

    // All metrics saturated: index 0 wins.
    pm = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
    for (int i = 0; i < 8; i++) push(2'($urandom));
    wait_valid(cyc);
    chk("sat_state", dec_state, 0);
    chk("sat_flag", dec_sat, 1);
    chk("sat_metric", dec_metric, 7'h7F);
    ack();

    // Flush after five symbols; the next symbol must land in column 1.
    for (int i = 0; i < 5; i++) push(2'b11);
    flush = 1'b1; sym_valid = 1'b1; sym_in = 2'b01;
    step();
    flush = 1'b0; sym_valid = 1'b0;
    for (int i = 0; i < 8; i++) chk("flush_recv", rv[i], 0);
    chk("flush_blk_cnt", blk_cnt, 2);
    push(2'b10);
    chk("flush_first", rv[0], 2'b10);
    for (int i = 1; i < 8; i++) push(2'($urandom));
    wait_valid(cyc);
    flush = 1'b1; dec_ready = 1'b1;
    step();
    flush = 1'b0; dec_ready = 1'b0;
    chk("flush_out_valid", dec_valid, 0);
    chk("flush_out_cnt", blk_cnt, 2);
    chk("flush_out_recv1", rv[0], 0);

    // Random traffic up to the 256th delivery, including random mid-block flushes.
    rand_pm = 1'b1;
    while (delivered < 256) begin
      aborted = 1'b0;
      for (int i = 0; i < 8 && !aborted; i++) begin
        repeat ($urandom % 3) step();
        if ($urandom % 40 == 0) begin
          flush = 1'b1; step(); flush = 1'b0;
          aborted = 1'b1;
        end else begin
          push(2'($urandom));
        end
      end
      if (!aborted) begin
        wait_valid(cyc);
        repeat ($urandom % 4) begin sym_valid = 1'($urandom); step(); end
        sym_valid = 1'b0;
        ack();
      end
    end
    chk("blk_cnt_wrap", blk_cnt, 0);

    // Asynchronous reset in the middle of HOLD.
    for (int i = 0; i < 8; i++) push(2'b11);
    step(); step(); step();
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", dec_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", sym_ready, 1);
    chk("arst_blk_cnt", blk_cnt, 0);
    chk("arst_recv8", rv[7], 0);
    chk("arst_dec_out", dec_out, 0);
    step();
    rst = 1'b1;
    push(2'b01);
    chk("arst_first", rv[0], 2'b01);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
